address_scan_counter: RTL and testbench
=======================================

Name: address_scan_counter

Overview:
- Parametrised 2D address generator. It is the successor to the single-purpose screen/sprite address counters and the fixed tick delay.
- On start it walks a COLS x ROWS rectangle row by row. Each step emits x, y and a linear memory address: base + y*STRIDE + x.
- Emission is paced by an optional clock divider and throttled by a valid/ready handshake.
- Sits between the game control FSM and the VGA/frame-buffer write port. Used both for full-screen clears (160x120) and for sprite blits (40x40 into a 160-wide screen).

Parameters:
- COLS, 160, rectangle width in pixels (>=1)
- ROWS, 120, rectangle height in pixels (>=1)
- STRIDE, 160, address increment per row (destination line pitch, >=COLS)
- ADDR_W, 15, address width; all address arithmetic is modulo 2^ADDR_W
- X_W, 8, width of pixelX (must hold COLS-1)
- Y_W, 7, width of pixelY (must hold ROWS-1)
- DIV, 1, minimum cycles between emitted pixels (>=1); DIV=1 means one pixel per cycle

Ports:
- clk  in  1  system clock, rising edge
- addressScanCounterResetn  in  1  asynchronous, active-low reset
- start  in  1  begin scan; sampled only in IDLE
- abort  in  1  terminate scan; no done pulse
- baseAddr  in  ADDR_W  start address; latched on accepted start
- pixelReady  in  1  consumer accepts current pixel
- pixelValid  out  1  pixelX/pixelY/pixelAddr are valid
- pixelX  out  X_W  column index, 0..COLS-1
- pixelY  out  Y_W  row index, 0..ROWS-1
- pixelAddr  out  ADDR_W  linear address of current pixel
- busy  out  1  high in SCAN
- done  out  1  one-cycle pulse after last pixel is transferred

Behaviour:
- Reset (asynchronous, Resetn=0):
  - state=IDLE.
  - pixelValid, busy and done are 0.
  - pixelX, pixelY, pixelAddr, internal rowBase and divCnt are 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - When start=1, latch x=0, y=0, pixelAddr=baseAddr, rowBase=baseAddr, divCnt=0, and go to SCAN on the next edge.
  - Otherwise hold all registers.
- SCAN:
  - busy=1.
  - pixelValid=1 iff divCnt==DIV-1. For DIV=1, pixelValid=1 every SCAN cycle, so the first pixel is valid in the cycle after start.
  - divCnt increments while below DIV-1 and saturates at DIV-1.
  - Transfer occurs when pixelValid and pixelReady are both 1.
  - While pixelValid=1 and pixelReady=0, x, y, pixelAddr and divCnt hold. Data stays stable until the transfer.
- On transfer:
  - divCnt resets to 0.
  - If x<COLS-1: x+=1 and pixelAddr+=1.
  - If x==COLS-1 and y<ROWS-1: x=0, y+=1, rowBase+=STRIDE, pixelAddr=rowBase+STRIDE.
  - If x==COLS-1 and y==ROWS-1: go to DONE; x, y and pixelAddr hold their last values.
- Address generation:
  - No multiplier; addresses are built incrementally.
  - Sums wrap modulo 2^ADDR_W; wrap-around is silent.
- DONE:
  - done=1, busy=0, pixelValid=0 for exactly one cycle, then IDLE.
  - start during DONE is ignored.
- abort:
  - In SCAN, abort=1 goes to IDLE next edge with no done pulse. pixelValid drops at that edge.
  - abort has priority over a simultaneous transfer; that pixel counts as transferred for the consumer, but no further pixels follow.
  - abort in IDLE or DONE has no effect.
- start while in SCAN or DONE is ignored; baseAddr is not re-latched.
- Simultaneous start and abort in IDLE: start wins and the scan begins.
- Degenerate sizes:
  - COLS=1 or ROWS=1 are legal.
  - COLS=ROWS=1 with DIV=1: one valid cycle, then DONE.
- Latency, from start accepted until done: COLS*ROWS transfers, plus stall cycles, plus (DIV-1) pacing cycles per pixel, plus 1.
- Reset asserted mid-scan returns to the reset values immediately, regardless of the clock.

Test Plan:
- COLS=4, ROWS=3, STRIDE=160, DIV=1; baseAddr=100, start pulse, pixelReady=1 → 12 consecutive valid cycles.
  - Addresses 100-103, 260-263, 420-423.
  - (x,y) goes (0,0)..(3,2).
  - done pulses one cycle after addr 423; busy low afterward.
- Same configuration; pixelReady=0 for 3 cycles on the pixel at addr 261 → pixelValid held high with addr=261, x=1, y=1 stable; the sequence resumes with 262 after ready returns.
- DIV=4, COLS=2, ROWS=1, base=0, pixelReady=1 → pixelValid high in cycles 4 and 8 after start (counting the first SCAN cycle as 1), addrs 0 and 1; done in cycle 9.
- 160x120 default, base=0; abort asserted at the pixel with addr 500 → IDLE next cycle, no done, busy=0. A second start with base=0 restarts at addr 0.
- ADDR_W=15, COLS=2, ROWS=2, STRIDE=160, base=32767 → addrs 32767, 0, 159, 160 (modulo wrap); start pulses during the scan are ignored.
- Resetn pulled low asynchronously mid-row (between edges) → all outputs 0 immediately. After release, the block stays in IDLE until the next start.

Source files
------------

// File: rtl/address_scan_counter.sv
// Parametrised 2D address generator: walks a COLS x ROWS rectangle row by row,
// emitting x, y and base + y*STRIDE + x under divider pacing and valid/ready flow control.
module address_scan_counter #(
  parameter int unsigned COLS   = 160,
  parameter int unsigned ROWS   = 120,
  parameter int unsigned STRIDE = 160,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned X_W    = 8,
  parameter int unsigned Y_W    = 7,
  parameter int unsigned DIV    = 1
) (
  input  logic              clk,
  input  logic              addressScanCounterResetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic              pixelReady,
  output logic              pixelValid,
  output logic [X_W-1:0]    pixelX,
  output logic [Y_W-1:0]    pixelY,
  output logic [ADDR_W-1:0] pixelAddr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [X_W-1:0]    X_LAST   = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state and datapath; flags are derived from the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    div_d      = div_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d        = '0;
          y_d        = '0;
          addr_d     = baseAddr;
          row_base_d = baseAddr;
          div_d      = '0;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        // abort beats a coincident transfer; position registers simply freeze
        if (abort) begin
          state_d = S_IDLE;
        end else if (valid_q && pixelReady) begin
          div_d = '0;
          if (x_q != X_LAST) begin
            x_d    = x_q + X_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end else if (y_q != Y_LAST) begin
            x_d        = '0;
            y_d        = y_q + Y_W'(1);
            row_base_d = row_base_q + STRIDE_A;
            addr_d     = row_base_q + STRIDE_A;
          end else begin
            state_d = S_DONE;
          end
        end else if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    valid_d = (state_d == S_SCAN) && (div_d == DIV_LAST);
    busy_d  = (state_d == S_SCAN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge addressScanCounterResetn) begin
    if (!addressScanCounterResetn) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      div_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      div_q      <= div_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pixelValid = valid_q;
  assign pixelX     = x_q;
  assign pixelY     = y_q;
  assign pixelAddr  = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_address_scan_counter.sv
// Self-checking bench for address_scan_counter over several parameter sets.
module tb_address_scan_counter;

  localparam int unsigned N = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st [N];
  logic        ab [N];
  logic        rd [N];
  logic [14:0] ba [N];
  logic        pv [N];
  logic [7:0]  px [N];
  logic [6:0]  py [N];
  logic [14:0] pa [N];
  logic        bz [N];
  logic        dn [N];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rdy;
    logic        v;
    int unsigned x;
    int unsigned y;
    int unsigned addr;
    logic        b;
    logic        d;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  // 0: 4x3 DIV1, 1: 2x1 DIV4, 2: 2x2 wrap, 3: default 160x120, 4: 1x1
  address_scan_counter #(.COLS(4), .ROWS(3), .STRIDE(160), .DIV(1)) u_a (
    .clk(clk), .addressScanCounterResetn(rst_n), .start(st[0]), .abort(ab[0]),
    .baseAddr(ba[0]), .pixelReady(rd[0]), .pixelValid(pv[0]), .pixelX(px[0]),
    .pixelY(py[0]), .pixelAddr(pa[0]), .busy(bz[0]), .done(dn[0]));
  address_scan_counter #(.COLS(2), .ROWS(1), .STRIDE(160), .DIV(4)) u_b (
    .clk(clk), .addressScanCounterResetn(rst_n), .start(st[1]), .abort(ab[1]),
    .baseAddr(ba[1]), .pixelReady(rd[1]), .pixelValid(pv[1]), .pixelX(px[1]),
    .pixelY(py[1]), .pixelAddr(pa[1]), .busy(bz[1]), .done(dn[1]));
  address_scan_counter #(.COLS(2), .ROWS(2), .STRIDE(160), .DIV(1)) u_c (
    .clk(clk), .addressScanCounterResetn(rst_n), .start(st[2]), .abort(ab[2]),
    .baseAddr(ba[2]), .pixelReady(rd[2]), .pixelValid(pv[2]), .pixelX(px[2]),
    .pixelY(py[2]), .pixelAddr(pa[2]), .busy(bz[2]), .done(dn[2]));
  address_scan_counter u_d (
    .clk(clk), .addressScanCounterResetn(rst_n), .start(st[3]), .abort(ab[3]),
    .baseAddr(ba[3]), .pixelReady(rd[3]), .pixelValid(pv[3]), .pixelX(px[3]),
    .pixelY(py[3]), .pixelAddr(pa[3]), .busy(bz[3]), .done(dn[3]));
  address_scan_counter #(.COLS(1), .ROWS(1), .STRIDE(160), .DIV(1)) u_e (
    .clk(clk), .addressScanCounterResetn(rst_n), .start(st[4]), .abort(ab[4]),
    .baseAddr(ba[4]), .pixelReady(rd[4]), .pixelValid(pv[4]), .pixelX(px[4]),
    .pixelY(py[4]), .pixelAddr(pa[4]), .busy(bz[4]), .done(dn[4]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input int idx, input string tag, input logic ev,
                         input int unsigned ex, input int unsigned ey, input int unsigned ea,
                         input logic eb, input logic ed);
    chk({tag, "_valid"}, 32'(pv[idx]), 32'(ev));
    chk({tag, "_x"},     32'(px[idx]), ex);
    chk({tag, "_y"},     32'(py[idx]), ey);
    chk({tag, "_addr"},  32'(pa[idx]), ea);
    chk({tag, "_busy"},  32'(bz[idx]), 32'(eb));
    chk({tag, "_done"},  32'(dn[idx]), 32'(ed));
  endtask

  // Ends at the negedge of the first SCAN cycle.
  task automatic do_start(input int idx, input logic [14:0] b);
    @(negedge clk);
    st[idx] = 1'b1;
    ba[idx] = b;
    @(negedge clk);
    st[idx] = 1'b0;
  endtask

  // Expected per-cycle trace of the 4x3 instance, with an optional stall on one pixel.
  task automatic build_a(input int unsigned b, input int stall_idx, input int stall_n);
    int unsigned a;
    vq.delete();
    a = 0;
    for (int yy = 0; yy < 3; yy++) begin
      for (int xx = 0; xx < 4; xx++) begin
        a = (b + 32'(yy) * 160 + 32'(xx)) % 32768;
        if (yy * 4 + xx == stall_idx)
          for (int s = 0; s < stall_n; s++)
            vq.push_back('{1'b0, 1'b1, 32'(xx), 32'(yy), a, 1'b1, 1'b0});
        vq.push_back('{1'b1, 1'b1, 32'(xx), 32'(yy), a, 1'b1, 1'b0});
      end
    end
    vq.push_back('{1'b1, 1'b0, 3, 2, a, 1'b0, 1'b1});
    vq.push_back('{1'b1, 1'b0, 3, 2, a, 1'b0, 1'b0});
  endtask

  task automatic run_a(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      rd[0] = vq[i].rdy;
      chk_out(0, $sformatf("%s_c%0d", tag, i), vq[i].v, vq[i].x, vq[i].y, vq[i].addr,
              vq[i].b, vq[i].d);
      @(negedge clk);
    end
  endtask

  initial begin
    bit found;
    int unsigned wrap_exp [4];
    for (int i = 0; i < int'(N); i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; rd[i] = 1'b0; ba[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < int'(N); i++)
      chk_out(i, $sformatf("rst%0d", i), 1'b0, 0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_out(0, "idle_after_rst", 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Full 4x3 scan, then the same scan with a 3-cycle stall on address 261
    do_start(0, 15'd100);
    build_a(100, -1, 0);
    run_a("scan");
    do_start(0, 15'd100);
    build_a(100, 5, 3);
    run_a("stall");

    // DIV=4 pacing: valid on cycles 4 and 8, done on 9
    rd[1] = 1'b1;
    do_start(1, 15'd0);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("div_valid_c%0d", c), 32'(pv[1]), 32'(c == 4 || c == 8));
      chk($sformatf("div_done_c%0d", c), 32'(dn[1]), 32'(c == 9));
      chk($sformatf("div_busy_c%0d", c), 32'(bz[1]), 32'(c < 9));
      if (c == 4) chk("div_addr0", 32'(pa[1]), 0);
      if (c == 8) chk("div_addr1", 32'(pa[1]), 1);
      @(negedge clk);
    end

    // Address wrap with ignored start pulses mid-scan
    wrap_exp[0] = 32767; wrap_exp[1] = 0; wrap_exp[2] = 159; wrap_exp[3] = 160;
    rd[2] = 1'b1;
    do_start(2, 15'd32767);
    for (int i = 0; i < 4; i++) begin
      st[2] = 1'b1;
      ba[2] = 15'd5;
      chk_out(2, $sformatf("wrap%0d", i), 1'b1, 32'(i % 2), 32'(i / 2), wrap_exp[i], 1'b1, 1'b0);
      @(negedge clk);
    end
    chk_out(2, "wrap_done", 1'b0, 1, 1, 160, 1'b0, 1'b1);
    @(negedge clk);
    st[2] = 1'b0;
    chk_out(2, "wrap_idle", 1'b0, 1, 1, 160, 1'b0, 1'b0);

    // Abort on the default 160x120 instance at address 500
    rd[3] = 1'b1;
    do_start(3, 15'd0);
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (pv[3] && pa[3] == 15'd500) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reach_500", 32'(found), 1);
    chk("abort_xy", {16'(px[3]), 16'(py[3])}, {16'd20, 16'd3});
    ab[3] = 1'b1;
    @(negedge clk);
    ab[3] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("abort_valid%0d", c), 32'(pv[3]), 0);
      chk($sformatf("abort_busy%0d", c), 32'(bz[3]), 0);
      chk($sformatf("abort_done%0d", c), 32'(dn[3]), 0);
      @(negedge clk);
    end
    ab[3] = 1'b1;
    @(negedge clk);
    ab[3] = 1'b0;
    chk("abort_idle_noeffect", 32'(bz[3]), 0);
    do_start(3, 15'd0);
    chk_out(3, "restart", 1'b1, 0, 0, 0, 1'b1, 1'b0);
    ab[3] = 1'b1;
    @(negedge clk);
    ab[3] = 1'b0;
    chk("restart_abort_busy", 32'(bz[3]), 0);

    // 1x1 with simultaneous start and abort in IDLE
    rd[4] = 1'b1;
    @(negedge clk);
    st[4] = 1'b1; ab[4] = 1'b1; ba[4] = 15'd77;
    @(negedge clk);
    st[4] = 1'b0; ab[4] = 1'b0;
    chk_out(4, "one_pix", 1'b1, 0, 0, 77, 1'b1, 1'b0);
    @(negedge clk);
    chk_out(4, "one_done", 1'b0, 0, 0, 77, 1'b0, 1'b1);
    @(negedge clk);
    chk_out(4, "one_idle", 1'b0, 0, 0, 77, 1'b0, 1'b0);

    // Asynchronous reset between edges mid-row
    rd[0] = 1'b1;
    do_start(0, 15'd100);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    chk("pre_reset_busy", 32'(bz[0]), 1);
    rst_n = 1'b0;
    #1;
    chk_out(0, "async_rst", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_out(0, "post_rst_idle", 1'b0, 0, 0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
